// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and operation encoding
// for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipelined_addsub_chunk_stage.sv
// One CHUNK-bit adder slice with its stage
// registers and bubble-collapsing ready logic.
module addsub_chunk_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] bx_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             carry_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] bx_o,
  output logic             msb_cin_o
);

  localparam int LO = IDX * CHUNK;
  localparam int HI = LO + CHUNK - 1;

  logic             valid_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] bx_q;
  logic             msb_q;
  logic             msb_d;
  logic [CHUNK:0]   sum;
  logic             load;

  assign ready_o = !valid_q || ready_i;
  assign load    = ready_o && valid_i;

  assign sum = {1'b0, acc_i[LO +: CHUNK]}
             + {1'b0, bx_i[LO +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_i};

  // acc carries finished result chunks below
  // this slice and raw A chunks above it.
  always_comb begin
    acc_d = acc_i;
    acc_d[LO +: CHUNK] = sum[CHUNK-1:0];
  end

  // carry into the slice MSB, recovered from
  // the MSB sum bit: s = a ^ b ^ cin.
  assign msb_d = acc_i[HI] ^ bx_i[HI] ^ sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      bx_q    <= '0;
      msb_q   <= 1'b0;
    end else begin
      if (ready_o) valid_q <= valid_i;
      if (load) begin
        carry_q <= sum[CHUNK];
        acc_q   <= acc_d;
        bx_q    <= bx_i;
        msb_q   <= msb_d;
      end
    end
  end

  assign valid_o   = valid_q;
  assign carry_o   = carry_q;
  assign acc_o     = acc_q;
  assign bx_o      = bx_q;
  assign msb_cin_o = msb_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-chunked add/sub: one CHUNK
// slice per stage, valid/ready on both sides.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic [STAGES:0]            vld_w;
  logic [STAGES:0]            rdy_w;
  logic [STAGES:0]            cy_w;
  logic [STAGES:0][WIDTH-1:0] acc_w;
  logic [STAGES:0][WIDTH-1:0] bx_w;
  logic                       msb_cin;
  logic [WIDTH-1:0]           bx_unused;
  logic                       sub_op;

  assign sub_op = (Sub == OP_SUB);

  // subtraction as A + ~B + ~Cin
  assign vld_w[0] = in_valid;
  assign acc_w[0] = A;
  assign bx_w[0]  = sub_op ? ~B : B;
  assign cy_w[0]  = sub_op ? ~Cin : Cin;

  assign rdy_w[STAGES] = out_ready;
  assign in_ready      = rst_n && rdy_w[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic msb_cin_k;

    addsub_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (vld_w[k]),
      .ready_o   (rdy_w[k]),
      .carry_i   (cy_w[k]),
      .acc_i     (acc_w[k]),
      .bx_i      (bx_w[k]),
      .valid_o   (vld_w[k+1]),
      .ready_i   (rdy_w[k+1]),
      .carry_o   (cy_w[k+1]),
      .acc_o     (acc_w[k+1]),
      .bx_o      (bx_w[k+1]),
      .msb_cin_o (msb_cin_k)
    );

    if (k == STAGES - 1) begin : g_last
      assign msb_cin = msb_cin_k;
    end else begin : g_mid
      logic msb_unused;
      assign msb_unused = msb_cin_k;
    end
  end

  assign bx_unused = bx_w[STAGES];

  assign out_valid = vld_w[STAGES];
  assign Z         = acc_w[STAGES];
  assign Cout      = cy_w[STAGES];
  assign Ovf       = msb_cin ^ cy_w[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Random + directed bench for pipelined_addsub
// against a plain-arithmetic scoreboard.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int NST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Z;
  logic         Cout;
  logic         Ovf;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] z;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic ci,
                                 input logic sb);
    logic [W:0] r;
    exp_t e;
    if (!sb) r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    else     r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
    e.z = r[W-1:0];
    e.c = sb ? ~r[W] : r[W];
    if (!sb) e.o = (a[W-1] == b[W-1]) && (e.z[W-1] != a[W-1]);
    else     e.o = (a[W-1] != b[W-1]) && (e.z[W-1] != a[W-1]);
    return e;
  endfunction

  // scoreboard: push on accept, pop on drain
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("Z", 32'(Z), 32'(e.z));
          chk("Cout", 32'(Cout), 32'(e.c));
          chk("Ovf", 32'(Ovf), 32'(e.o));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        q.push_back(model(A, B, Cin, Sub));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic ci,
                     input logic sb,
                     input logic [W-1:0] ez,
                     input logic ec,
                     input logic eo);
    int lat;
    cyc();
    A = a; B = b; Cin = ci; Sub = sb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NST));
    chk({tag, "_Z"}, 32'(Z), 32'(ez));
    chk({tag, "_Cout"}, 32'(Cout), 32'(ec));
    chk({tag, "_Ovf"}, 32'(Ovf), 32'(eo));
  endtask

  logic [W-1:0] bp_a[6];
  logic [W-1:0] bp_b[6];

  initial begin
    int acc;
    int drains;
    logic [W-1:0] zh;

    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 16'h1234;
    B = 16'h1234;
    Cin = 1'b0;
    Sub = 1'b0;
    out_ready = 1'b1;

    // reset with live input
    repeat (3) begin
      cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_Z", 32'(Z), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin
      cyc();
      chk("rst_no_out", 32'(out_valid), 32'd0);
    end

    dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
        16'h0000, 1'b1, 1'b0);
    dir("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
        16'h8000, 1'b0, 1'b1);
    dir("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0,
        16'h0000, 1'b1, 1'b1);
    dir("sub_bor", 16'h0005, 16'h0007, 1'b0, 1'b1,
        16'hFFFE, 1'b0, 1'b0);
    dir("sub_bin", 16'h0005, 16'h0007, 1'b1, 1'b1,
        16'hFFFD, 1'b0, 1'b0);
    repeat (2) cyc();

    // back-pressure: fill with out_ready low
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    out_ready = 1'b0;
    Sub = 1'b0;
    Cin = 1'b0;
    acc = 0;
    repeat (8) begin
      cyc();
      in_valid = (acc < 6);
      A = bp_a[acc % 6];
      B = bp_b[acc % 6];
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    zh = Z;
    repeat (3) begin
      cyc();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_Z", 32'(Z), 32'(zh));
    end

    // release: remaining inputs plus drain
    drains = 0;
    repeat (8) begin
      cyc();
      out_ready = 1'b1;
      in_valid = (acc < 6);
      A = bp_a[acc % 6];
      B = bp_b[acc % 6];
      @(negedge clk);
      if (out_valid) drains++;
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    chk("bp_total_in", 32'(acc), 32'd6);
    chk("bp_drains", 32'(drains), 32'd6);
    chk("bp_q_empty", 32'(q.size()), 32'd0);

    // reset with three in flight
    for (int i = 0; i < 3; i++) begin
      cyc();
      in_valid = 1'b1;
      A = 16'($urandom);
      B = 16'($urandom);
    end
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_out", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    n_out = 0;
    dir("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0,
        16'h0003, 1'b0, 1'b0);
    repeat (6) cyc();
    chk("post_rst_count", 32'(n_out), 32'd1);

    // random traffic
    repeat (600) begin
      cyc();
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      A = 16'($urandom);
      B = 16'($urandom);
      Cin = 1'($urandom);
      Sub = 1'($urandom);
    end
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    chk("rand_q_empty", 32'(q.size()), 32'd0);
    chk("rand_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
